// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate-extension pipeline: extension modes and skid-buffer states.
// No logic; latency and backpressure are defined by the users of these types.
package imm_ext_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_ZERO      = 2'd0,
    MODE_SIGN      = 2'd1,
    MODE_SIGN_SHL2 = 2'd2,
    MODE_UPPER     = 2'd3
  } imm_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: zero, sign, sign<<2 or upper placement of an IN_W field.
// Zero latency, no handshake; the caller registers and flow-controls the result.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  imm_mode_e        mode,
  input  logic [IN_W-1:0]  imm,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] upper;

  // A full-width field has nothing to pad, so every placement is the field itself.
  generate
    if (IN_W == OUT_W) begin : g_full
      assign zext  = imm;
      assign sext  = imm;
      assign upper = imm;
    end else begin : g_pad
      assign zext  = {{(OUT_W-IN_W){1'b0}}, imm};
      assign sext  = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
      assign upper = {imm, {(OUT_W-IN_W){1'b0}}};
    end
  endgenerate

  always_comb begin
    ext = zext;
    case (mode)
      MODE_ZERO:      ext = zext;
      MODE_SIGN:      ext = sext;
      MODE_SIGN_SHL2: ext = sext << 2;
      MODE_UPPER:     ext = upper;
      default:        ext = zext;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender with valid/ready on both sides; 1-cycle latency when empty.
// Two-entry skid (main + skid regs); in_ready is registered and drops only when both are full.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic [OUT_W-1:0] ext_dat;
  logic             in_xfer;
  logic             out_xfer;

  buf_state_e       state_q,    state_d;
  logic             in_ready_q, in_ready_d;
  logic [OUT_W-1:0] main_dat_q, main_dat_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic [OUT_W-1:0] skid_dat_q, skid_dat_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .mode (imm_mode_e'(in_mode)),
    .imm  (in_imm),
    .ext  (ext_dat)
  );

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    main_dat_d = main_dat_q;
    main_tag_d = main_tag_q;
    skid_dat_d = skid_dat_q;
    skid_tag_d = skid_tag_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_dat_d = ext_dat;
          main_tag_d = in_tag;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          main_dat_d = ext_dat;
          main_tag_d = in_tag;
        end else if (in_xfer) begin
          skid_dat_d = ext_dat;
          skid_tag_d = in_tag;
          state_d    = ST_TWO;
        end else if (out_xfer) begin
          state_d    = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          main_dat_d = skid_dat_q;
          main_tag_d = skid_tag_q;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Registered ready: looks at the next state, never at out_ready this cycle.
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_dat_q <= '0;
      main_tag_q <= '0;
      skid_dat_q <= '0;
      skid_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_dat_q <= main_dat_d;
      main_tag_q <= main_tag_d;
      skid_dat_q <= skid_dat_d;
      skid_tag_q <= skid_tag_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_dat_q;
  assign out_tag   = main_tag_q;

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the decode stage.
- Generalises a fixed 16-to-32 sign extender. Adds a runtime-selectable mode: zero-extend, sign-extend, sign-extend with shift-left-2 (branch offsets), and upper placement (LUI).
- Has valid/ready handshakes on both sides and a 2-entry skid buffer, so decode can stall without dropping immediates.
- Sits between the instruction-field splitter and the ALU/branch-target operand muxes.

Parameters:
- IN_W, 16, immediate input width; legal range 1..OUT_W.
- OUT_W, 32, extended output width.
- TAG_W, 5, width of the sideband tag (for example, destination register index) carried alongside the data.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream offers an immediate this cycle.
- in_ready  output  1  unit can accept an immediate this cycle.
- in_imm  input  IN_W  raw immediate field.
- in_mode  input  2  extension mode: 0 ZERO, 1 SIGN, 2 SIGN_SHL2, 3 UPPER.
- in_tag  input  TAG_W  sideband tag, passed through unmodified.
- out_valid  output  1  extended result available.
- out_ready  input  1  downstream accepts the result this cycle.
- out_data  output  OUT_W  extended result.
- out_tag  output  TAG_W  tag associated with out_data.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_tag=0, in_ready=1; both buffer entries are cleared. Reset asserted mid-transfer discards all held entries, with no partial output.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Latency: 1 cycle. An input accepted at edge N appears on out_data after edge N when the buffer was empty.
- Extension is computed combinationally on the input side and registered:
  - ZERO: {(OUT_W-IN_W) zeros, in_imm}.
  - SIGN: {(OUT_W-IN_W) copies of in_imm[IN_W-1], in_imm}.
  - SIGN_SHL2: the SIGN result shifted left 2, truncated to OUT_W, with zeros in the two LSBs.
  - UPPER: in_imm placed in bits [OUT_W-1 : OUT_W-IN_W], zeros below. When IN_W==OUT_W the result equals in_imm.
  - When IN_W==OUT_W, ZERO and SIGN both pass in_imm unchanged.
- Buffer state machine (main register drives the outputs; skid register holds overflow):
  - EMPTY: out_valid=0, in_ready=1. Input transfer -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Output transfer and no input -> EMPTY.
    - Input transfer and output transfer in the same cycle -> ONE; main takes the new data.
    - Input transfer and no output transfer -> TWO; skid takes the new data.
    - Neither -> ONE; main holds.
  - TWO: out_valid=1, in_ready=0, and in_valid is ignored.
    - Output transfer -> ONE; main takes the skid contents.
    - Otherwise hold.
- in_ready is a registered signal: it is low only in TWO and never depends combinationally on out_ready.
- out_data and out_tag are stable while out_valid && !out_ready.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- in_imm, in_mode and in_tag are sampled only on an input transfer. Values on those inputs while in_valid=0 have no effect.

Decomposition:
- Shared package imm_ext_pkg holds:
  - the mode typedef (2-bit enum ZERO/SIGN/SIGN_SHL2/UPPER);
  - the buffer state typedef (EMPTY/ONE/TWO);
  - the constant MODE_W=2.
- One sub-module, imm_ext_core: purely combinational, parametrised by IN_W and OUT_W, with mode and imm in and extended value out. It is instantiated once on the input side. The top level holds the handshake state machine and the two registers.

Test Plan:
- Reset, then in_imm=16'h8001, mode SIGN, out_ready=1 -> after 1 edge out_valid=1 and out_data=32'hFFFF8001; next cycle out_valid=0.
- Same input value with mode ZERO -> 32'h00008001. Mode SIGN_SHL2 -> 32'hFFFE0004. Mode UPPER -> 32'h80010000.
- Back-pressure: out_ready=0, send tags 1, 2, 3 on consecutive cycles -> tags 1 and 2 accepted; in_ready falls after the second transfer; tag 3 is held upstream. Raising out_ready yields tags 1, 2, 3 in order, with data unchanged while stalled.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with an incrementing imm -> one result per cycle, in_ready constantly 1, no bubbles after the first.
- Asynchronous reset pulse between edges while in TWO -> out_valid drops and in_ready rises immediately, before the next edge; after release, the first new input appears with 1-cycle latency.
- Instance with IN_W=12, OUT_W=32: in_imm=12'hFFF with SIGN -> 32'hFFFFFFFF; with UPPER -> 32'hFFF00000.
